ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx_if.sv | 21 ++
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake and completion status between a host client and ps2_host_tx.
interface ps2_host_tx_if;
    localparam int unsigned DATA_W = 8;

    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              done;
    logic              nack;
    logic              err_timeout;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, done, nack, err_timeout
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, done, nack, err_timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame, wait for bus idle.
// Optional macro PS2_TX_ACK_CHECK_EN: sample the device ack bit and report nack with done.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned RTS_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_host_tx_if.slave   tx,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);
    localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned IDX_W   = 4;

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             par_q, par_nxt;
    logic             clk_oe_q, clk_oe_nxt;
    logic             data_oe_q, data_oe_nxt;
    logic             ready_q, ready_nxt;
    logic             done_q, done_nxt;
    logic             nack_q, nack_nxt;
    logic             err_q, err_nxt;
    logic             ack_ok, ack_ok_nxt;
    logic             to_hit;

    logic clk_s1, clk_s2, clk_s3, data_s1, data_s2, fe;

    // Pin synchronizers and registered falling-edge detect (fe is 3 cycles behind the pin).
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            fe      <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            fe      <= clk_s3 & ~clk_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_ok    <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            data_q    <= data_nxt;
            par_q     <= par_nxt;
            clk_oe_q  <= clk_oe_nxt;
            data_oe_q <= data_oe_nxt;
            ready_q   <= ready_nxt;
            done_q    <= done_nxt;
            nack_q    <= nack_nxt;
            err_q     <= err_nxt;
            ack_ok    <= ack_ok_nxt;
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign to_hit  = !fe && (cnt == TO_LAST);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        data_nxt    = data_q;
        par_nxt     = par_q;
        clk_oe_nxt  = clk_oe_q;
        data_oe_nxt = data_oe_q;
        ready_nxt   = ready_q;
        done_nxt    = 1'b0;
        nack_nxt    = 1'b0;
        err_nxt     = 1'b0;
        ack_ok_nxt  = ack_ok;

        case (state)
            S_IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                ready_nxt   = 1'b1;
                if (tx.tx_valid && ready_q) begin
                    data_nxt    = tx.tx_data;
                    par_nxt     = ~^tx.tx_data;
                    bit_idx_nxt = '0;
                    cnt_nxt     = '0;
                    clk_oe_nxt  = 1'b1;
                    ready_nxt   = 1'b0;
                    ack_ok_nxt  = 1'b1;
                    state_nxt   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_nxt     = '0;
                    data_oe_nxt = 1'b1;
                    state_nxt   = S_RTS;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_RTS: begin
                if (cnt == RTS_LAST) begin
                    cnt_nxt    = '0;
                    clk_oe_nxt = 1'b0;
                    state_nxt  = S_SEND;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_SEND, S_ACK, S_WAIT_IDLE: begin
                // Device-clock watchdog: an fe on the expiry cycle still wins.
                if (to_hit) begin
                    err_nxt     = 1'b1;
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b0;
                    ready_nxt   = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_nxt = fe ? '0 : cnt_inc;
                    if (state == S_SEND && fe) begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                        if (bit_idx < IDX_W'(8)) begin
                            data_oe_nxt = ~data_q[bit_idx[2:0]];
                        end else if (bit_idx == IDX_W'(8)) begin
                            data_oe_nxt = ~par_q;
                        end else begin
                            data_oe_nxt = 1'b0;
                            state_nxt   = S_ACK;
                        end
                    end else if (state == S_ACK && fe) begin
`ifdef PS2_TX_ACK_CHECK_EN
                        ack_ok_nxt = ~data_s2;
`endif
                        state_nxt  = S_WAIT_IDLE;
                    end else if (state == S_WAIT_IDLE && clk_s2 && data_s2) begin
                        done_nxt  = 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
                        nack_nxt  = ~ack_ok;
`else
                        nack_nxt  = 1'b0;
`endif
                        ready_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                ready_nxt   = 1'b1;
                state_nxt   = S_IDLE;
            end
        endcase
    end

    assign ps2_clk_oe     = clk_oe_q;
    assign ps2_data_oe    = data_oe_q;
    assign tx.tx_ready    = ready_q;
    assign tx.done        = done_q;
    assign tx.nack        = nack_q;
    assign tx.err_timeout = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a PS/2 device model and a frame-level scoreboard.
module tb_ps2_host_tx;
    localparam int unsigned INH  = 40;
    localparam int unsigned RTS  = 8;
    localparam int unsigned TO   = 600;
    localparam int          HALF = 15;

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_ABORT4 = 3;

    typedef struct packed {
        logic       is_timeout;
        logic       nack;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low, dev_data_low;
    logic clk_pin, data_pin;

    ps2_host_tx_if tx_bus ();

    assign clk_pin  = ~(ps2_clk_oe | dev_clk_low);
    assign data_pin = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx(tx_bus.slave),
        .ps2_clk(clk_pin), .ps2_data(data_pin),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int events = 0;
    int dev_mode = M_ACK;
    int dev_clocks = 0;
    exp_t exp_q[$];
    logic [9:0] cap_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    // Device: answers a request-to-send with 10 data clocks and an ack clock.
    task automatic run_frame();
        logic [9:0] bits;
        int n;
        bits = '0;
        n = (dev_mode == M_ABORT4) ? 4 : 10;
        dev_clocks = 0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[k] = data_pin;
            dev_clk_low = 1'b0;
            dev_clocks++;
            repeat (HALF) @(negedge clk);
        end
        if (dev_mode != M_ABORT4) begin
            if (dev_mode == M_ACK) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            cap_q.push_back(bits);
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    initial begin
        logic prev_clk;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        prev_clk = 1'b1;
        forever begin
            @(negedge clk);
            if (!prev_clk && clk_pin && !data_pin && dev_mode != M_SILENT) run_frame();
            prev_clk = clk_pin;
        end
    end

    // Scoreboard monitor: every done/err_timeout consumes one expectation.
    always @(negedge clk) begin
        if (!rst && (tx_bus.done || tx_bus.err_timeout)) begin
            exp_t e;
            logic [9:0] fr;
            events++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(tx_bus.done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {30'd0, tx_bus.done, tx_bus.err_timeout},
                      {30'd0, ~e.is_timeout, e.is_timeout});
                if (!e.is_timeout) begin
                    check("nack", 32'(tx_bus.nack), 32'(e.nack));
                    if (cap_q.size() == 0) begin
                        check("frame_missing", 32'(0), 32'(1));
                    end else begin
                        fr = cap_q.pop_front();
                        check("frame_bits", 32'(fr), 32'(ref_frame(e.data)));
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input int m, input bit poke);
        int n, hi, rise, c, ev0;
        exp_t e;
        dev_mode = m;
        e.is_timeout = (m == M_SILENT);
        e.nack = ACK_CHK && (m == M_NACK);
        e.data = d;
        if (m != M_ABORT4) exp_q.push_back(e);
        n = 0;
        while (!tx_bus.tx_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("ready_wait_expired", 32'(0), 32'(1));
        ev0 = events;
        tx_bus.tx_valid = 1'b1;
        tx_bus.tx_data = d;
        @(negedge clk);
        tx_bus.tx_valid = 1'b0;
        hi = 0;
        rise = -1;
        while (ps2_clk_oe && hi < 1000) begin
            if (ps2_data_oe && rise < 0) rise = hi;
            if (poke && hi == 10) begin
                check("busy_ready_low", 32'(tx_bus.tx_ready), 32'(0));
                tx_bus.tx_valid = 1'b1;
                tx_bus.tx_data = 8'h55;
            end else begin
                tx_bus.tx_valid = 1'b0;
            end
            hi++;
            @(negedge clk);
        end
        tx_bus.tx_valid = 1'b0;
        check("clk_oe_high_len", 32'(hi), 32'(INH + RTS));
        check("data_oe_rise_at", 32'(rise), 32'(INH));
        check("start_bit_held", 32'(ps2_data_oe), 32'(1));
        if (m == M_SILENT) begin
            c = 0;
            while (!tx_bus.err_timeout && c < int'(TO) + 50) begin @(negedge clk); c++; end
            check("timeout_latency", 32'(c), 32'(TO));
            check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'(0));
            check("timeout_no_done", 32'(tx_bus.done), 32'(0));
        end
        if (m != M_ABORT4) begin
            n = 0;
            while (events == ev0 && n < 3000) begin @(negedge clk); n++; end
            if (n >= 3000) check("event_wait_expired", 32'(0), 32'(1));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        tx_bus.tx_valid = 1'b0;
        tx_bus.tx_data = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(tx_bus.tx_ready), 32'(1));
        check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'(0));
        check("reset_pulses", {29'd0, tx_bus.done, tx_bus.nack, tx_bus.err_timeout}, 32'(0));

        send(8'hED, M_ACK, 1'b1);
        send(8'h01, M_ACK, 1'b0);
        send(8'hFF, M_ACK, 1'b0);
        for (int i = 0; i < 8; i++)
            send(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 1'b0);
        send(8'h3C, M_NACK, 1'b0);
        send(8'hA7, M_SILENT, 1'b0);

        // Mid-frame reset after the fourth device clock.
        send(8'hA5, M_ABORT4, 1'b0);
        n = 0;
        while (!(dev_mode == M_ABORT4 && dev_clocks == 4) && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) check("abort_wait_expired", 32'(0), 32'(1));
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'(0));
        check("midreset_ready", 32'(tx_bus.tx_ready), 32'(1));
        repeat (3 * HALF) @(negedge clk);
        send(8'hF4, M_ACK, 1'b0);

        repeat (20) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
